// File: rtl/store_sequencer_pkg.sv
// Shared constants for the store sequencer: FSM state encoding, store-type codes
// and the default memory read latency.
package store_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SW     = 2'b00,
    SH     = 2'b01,
    SB     = 2'b10,
    SW_ALT = 2'b11
  } store_type_e;

  localparam int MEM_LAT_DEFAULT = 1;

  // Sub-word stores must read the old word first so the untouched bytes survive.
  function automatic logic needs_read(input logic [1:0] store_type);
    return (store_type == SH) || (store_type == SB);
  endfunction

endpackage

// File: rtl/store_sequencer_if.sv
// Request and memory-side signals of the store sequencer, bundled as one interface.
interface store_sequencer_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] b_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  modport master (
    output start, store_type, addr, b_data, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata, busy, done
  );

  modport slave (
    input  start, store_type, addr, b_data, mem_rdata,
    output mem_addr, mem_wr, mem_wdata, busy, done
  );
endinterface

// File: rtl/StoreMask.sv
// Merges register store data into the previously read memory word.
// Sub-word data goes into the upper bytes; the rest of the word comes from memory.
module StoreMask
  import store_sequencer_pkg::*;
(
  input  logic [31:0] B,
  input  logic [31:0] MR,
  input  logic [1:0]  CT,
  output logic [31:0] OUT
);

  always_comb begin
    OUT = B;
    case (CT)
      SH:      OUT = (B << 16) | (MR & 32'h0000_FFFF);
      SB:      OUT = (B << 24) | (MR & 32'h00FF_FFFF);
      default: OUT = B;
    endcase
  end

endmodule

// File: rtl/store_sequencer.sv
// Sequences one memory store: word stores write directly, sub-word stores do a
// read-modify-write with a fixed MEM_LAT-cycle read latency.
module store_sequencer
  import store_sequencer_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  store_sequencer_if.slave bus
);

  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] b_q, b_d;
  logic [31:0] mr_q, mr_d;
  logic [1:0]  ct_q, ct_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] merged;

  StoreMask u_mask (
    .B   (b_q),
    .MR  (mr_q),
    .CT  (ct_q),
    .OUT (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      b_q     <= '0;
      mr_q    <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      b_q     <= b_d;
      mr_q    <= mr_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    b_d     = b_q;
    mr_d    = mr_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Request is captured here so later input changes cannot disturb it.
        if (bus.start) begin
          addr_d  = bus.addr;
          b_d     = bus.b_data;
          ct_d    = bus.store_type;
          cnt_d   = '0;
          state_d = needs_read(bus.store_type) ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LATCH: begin
        mr_d    = bus.mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.mem_wr    = (state_q == ST_WRITE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if ((state_q == ST_READ) || (state_q == ST_LATCH) || (state_q == ST_WRITE)) begin
      bus.mem_addr = addr_q;
    end
    if (state_q == ST_WRITE) begin
      bus.mem_wdata = merged;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer with MEM_LAT=1 and MEM_LAT=3 instances
// behind a latency-accurate memory model.
module tb_store_sequencer;
  import store_sequencer_pkg::*;

  typedef struct {
    int          wr_c;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_drv;
  logic [1:0]  type_drv;
  logic [31:0] addr_drv, b_drv;
  int          sel;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] ovr_addr, ovr_data;
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  exp_t        exp_q [$];
  int          act_start = -100, act_end = -100, act_done_c = -100;
  logic [31:0] act_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_sequencer_if bus1 ();
  store_sequencer_if bus3 ();

  assign bus1.start      = start_drv && (sel == 0);
  assign bus1.store_type = type_drv;
  assign bus1.addr       = addr_drv;
  assign bus1.b_data     = b_drv;
  assign bus1.mem_rdata  = pipe1;
  assign bus3.start      = start_drv && (sel == 1);
  assign bus3.store_type = type_drv;
  assign bus3.addr       = addr_drv;
  assign bus3.b_data     = b_drv;
  assign bus3.mem_rdata  = pipe3[2];

  store_sequencer #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  store_sequencer #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ovr_addr) return ovr_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory returns the word for an address exactly MEM_LAT cycles after it appears.
  always @(posedge clk) pipe1 <= mem_word(bus1.mem_addr);
  always @(posedge clk) begin
    pipe3[0] <= mem_word(bus3.mem_addr);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  function automatic logic [31:0] merge_model(input logic [1:0] t, input logic [31:0] b,
                                              input logic [31:0] m);
    if (t == 2'b01) return ((b & 32'hFFFF) << 16) | (m & 32'hFFFF);
    if (t == 2'b10) return ((b & 32'hFF) << 24) | (m & 32'hFF_FFFF);
    return b;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble();
    type_drv = 2'($urandom_range(3, 0));
    addr_drv = $urandom;
    b_drv    = $urandom;
  endtask

  task automatic pulse(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    int   c, lat;
    exp_t e;
    type_drv  = t;
    addr_drv  = a;
    b_drv     = b;
    start_drv = 1'b1;
    c = cyc;
    if (c > act_end && !reset) begin
      lat = (t == 2'b01 || t == 2'b10) ? ((sel == 0) ? 1 : 3) + 2 : 1;
      e.wr_c  = c + lat;
      e.addr  = a;
      e.wdata = merge_model(t, b, mem_word(a));
      exp_q.push_back(e);
      act_start  = c;
      act_end    = c + lat + 1;
      act_done_c = c + lat + 1;
      act_addr   = a;
      $display("store dut=%0d cyc=%0d type=%b addr=%h b=%h accepted, write@%0d data=%h",
               sel, c, t, a, b, e.wr_c, e.wdata);
    end else begin
      $display("store dut=%0d cyc=%0d type=%b addr=%h b=%h ignored", sel, c, t, a, b);
    end
    step();
    start_drv = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    while (cyc <= act_end) step();
  endtask

  // Reset held for one edge: everything after the current cycle is cancelled.
  task automatic do_reset();
    $display("reset dut=%0d cyc=%0d", sel, cyc);
    reset = 1'b1;
    if (act_end > cyc) act_end = cyc;
    if (act_done_c > cyc) act_done_c = -100;
    while (exp_q.size() > 0 && exp_q[$].wr_c > cyc) void'(exp_q.pop_back());
    step();
    reset = 1'b0;
  endtask

  task automatic random_phase(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(3, 0)) begin
        scramble();
        step();
      end
      r = $urandom_range(9, 0);
      if (r < 4) wait_idle();
      if (r < 8) pulse(2'($urandom_range(3, 0)), $urandom, $urandom);
      else if (cyc <= act_end) do_reset();
    end
    wait_idle();
  endtask

  initial begin
    logic [31:0] m_addr, m_wdata, e_addr;
    logic        m_wr, m_busy, m_done, o_wr, o_busy, e_busy, e_done, e_wr;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sel == 0) begin
        m_addr = bus1.mem_addr; m_wdata = bus1.mem_wdata; m_wr = bus1.mem_wr;
        m_busy = bus1.busy;     m_done = bus1.done;
        o_wr   = bus3.mem_wr;   o_busy = bus3.busy;
      end else begin
        m_addr = bus3.mem_addr; m_wdata = bus3.mem_wdata; m_wr = bus3.mem_wr;
        m_busy = bus3.busy;     m_done = bus3.done;
        o_wr   = bus1.mem_wr;   o_busy = bus1.busy;
      end
      e_busy = (act_start < cyc) && (cyc <= act_end);
      e_done = (cyc == act_done_c);
      e_addr = (e_busy && !e_done) ? act_addr : 32'h0;
      e_wr   = (exp_q.size() > 0) && (exp_q[0].wr_c == cyc);
      check1("busy", m_busy, e_busy);
      check1("done", m_done, e_done);
      check1("mem_wr", m_wr, e_wr);
      check32("mem_addr", m_addr, e_addr);
      if (e_wr) begin
        check32("mem_wdata", m_wdata, exp_q[0].wdata);
        void'(exp_q.pop_front());
      end else begin
        check32("mem_wdata_idle", m_wdata, 32'h0);
      end
      check1("other_wr", o_wr, 1'b0);
      check1("other_busy", o_busy, 1'b0);
    end
  end

  initial begin
    reset     = 1'b1;
    start_drv = 1'b0;
    type_drv  = 2'b00;
    addr_drv  = '0;
    b_drv     = '0;
    sel       = 0;
    ovr_addr  = 32'hFFFF_FFF0;
    ovr_data  = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // MEM_LAT = 1
    pulse(SW, 32'h40, 32'hDEAD_BEEF);
    wait_idle();
    ovr_addr = 32'h100; ovr_data = 32'h5566_7788;
    pulse(SH, 32'h100, 32'h1234_ABCD);
    wait_idle();
    ovr_addr = 32'h180; ovr_data = 32'hA5A5_C3C3;
    pulse(SH, 32'h180, 32'h1111_1111);
    pulse(SH, 32'h180, 32'h2222_2222);
    while (cyc < act_done_c) step();
    pulse(SW, 32'h180, 32'h3333_3333);
    wait_idle();
    pulse(SW_ALT, 32'h44, 32'hCAFE_F00D);
    wait_idle();
    pulse(SW, 32'h48, 32'h0BAD_F00D);
    do_reset();
    wait_idle();
    random_phase(25);
    step();

    // MEM_LAT = 3
    sel = 1;
    ovr_addr = 32'h200; ovr_data = 32'h1122_3344;
    pulse(SB, 32'h200, 32'h0000_00EE);
    wait_idle();
    pulse(SH, 32'h204, 32'h9999_8888);
    while (cyc < act_start + 4) step();
    do_reset();
    pulse(SW, 32'h208, 32'h7654_3210);
    wait_idle();
    random_phase(25);

    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, meaning cycles from mem_addr valid to mem_rdata valid (legal range 1..7).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  store request, sampled only in IDLE.
REQ-005 The block SHALL have port store_type  input  2  00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-006 The block SHALL have port addr  input  32  store address, passed unmodified to memory.
REQ-007 The block SHALL have port b_data  input  32  register-file store data.
REQ-008 The block SHALL have port mem_rdata  input  32  memory read data.
REQ-009 The block SHALL have port mem_addr  output  32  memory address.
REQ-010 The block SHALL have port mem_wr  output  1  memory write strobe, high exactly one cycle per store.
REQ-011 The block SHALL have port mem_wdata  output  32  merged word to write.
REQ-012 The block SHALL have ports busy  output  1 (high in every state except IDLE) and done  output  1 (one-cycle completion pulse).

Function
REQ-013 The FSM SHALL have states IDLE, READ, LATCH, WRITE and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch addr, b_data and store_type into addr_q, b_q and ct_q on that edge.
REQ-015 IDLE SHALL go to WRITE for ct_q 00/11, and to READ for ct_q 01/10.
REQ-016 READ SHALL hold for exactly MEM_LAT cycles, using a 3-bit counter cleared on entry, then go to LATCH.
REQ-017 LATCH SHALL capture mem_rdata into mr_q and go to WRITE.
REQ-018 WRITE SHALL assert mem_wr=1 for one cycle and go to DONE.
REQ-019 DONE SHALL assert done=1 for one cycle and go to IDLE.
REQ-020 mem_addr SHALL equal addr_q in READ, LATCH and WRITE, and 0 otherwise.
REQ-021 mem_wdata SHALL be 0 outside WRITE.
REQ-022 Merge rules:
- ct 00/11: mem_wdata = b_q.
- ct 01: mem_wdata[31:16] = b_q[15:0], mem_wdata[15:0] = mr_q[15:0].
- ct 10: mem_wdata[31:24] = b_q[7:0], mem_wdata[23:0] = mr_q[23:0].
REQ-023 Latency from the start-accept edge SHALL be:
- word: WRITE at +1 cycle, done at +2.
- halfword/byte: WRITE at MEM_LAT+2, done at MEM_LAT+3.
REQ-024 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing.
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight store.
REQ-026 mem_wr SHALL never be asserted outside WRITE, so at most one write occurs per accepted start.
REQ-027 Back-to-back stores SHALL be accepted no sooner than the cycle after done.

Reset
REQ-028 reset=1 SHALL force IDLE on the next edge from any state, with priority over start.
REQ-029 On reset, busy, done, mem_wr, mem_addr, mem_wdata, addr_q, b_q, mr_q, ct_q and the counter SHALL all be 0.
REQ-030 A reset asserted in READ or LATCH SHALL produce no write.
REQ-031 A reset asserted in WRITE SHALL deassert mem_wr on that same edge, with no second write afterwards.

Structure
REQ-032 State encodings, store_type codes (SW=00, SH=01, SB=10) and the MEM_LAT default SHALL reside in the shared CPU constants package/include.
REQ-033 The merge SHALL be one sub-module, StoreMask (inputs B, MR, CT; output OUT), instantiated with B=b_q, MR=mr_q, CT=ct_q.
REQ-034 The FSM, counter and registers SHALL be in store_sequencer; target size is 120-250 lines.

Verification
REQ-035 The bench SHALL cover word store: MEM_LAT=1, start, type 00, addr 0x40, b 0xDEADBEEF -> mem_wr one cycle at +1 with wdata 0xDEADBEEF, addr 0x40; done at +2; no read cycles.
REQ-036 The bench SHALL cover halfword store: type 01, b 0x1234ABCD, mem_rdata 0x55667788 -> mem_wr at +3 with wdata 0xABCD7788; done at +4.
REQ-037 The bench SHALL cover byte store with MEM_LAT=3: type 10, b 0x000000EE, mem_rdata 0x11223344 -> mem_wr at +5 with wdata 0xEE223344; done at +6.
REQ-038 The bench SHALL cover ignored start: a second start with a different b_data during READ and during DONE -> ignored; exactly one mem_wr, with the first store's data.
REQ-039 The bench SHALL cover reset mid-operation: reset in LATCH -> IDLE next edge, all outputs 0, zero mem_wr pulses; a following word store completes normally.
REQ-040 The bench SHALL cover type 11: type 11, b 0xCAFEF00D -> behaves as word store, wdata 0xCAFEF00D, done at +2.
